ooo_bypass_network: RTL and testbench
=====================================

Name: ooo_bypass_network

Overview:
- Parametrised successor to the out-of-order bypass unit.
- Forwards results from NUM_SRC functional-unit writeback channels to NUM_RD operand read ports.
- Adds a HOLD_DEPTH-stage result history buffer, so a consumer issued up to HOLD_DEPTH cycles after a producer's writeback still receives the bypassed value before the register file reflects it.
- Sits between the execute writeback channels and decode/issue operand read; also supports flush.

Parameters:
- NUM_SRC, 4, writeback channels (fixed order: 0=alu, 1=mul, 2=div, 3=lsu).
- NUM_RD, 2, operand read ports (rs1, rs2, ...).
- HOLD_DEPTH, 2, history stages retained after the writeback cycle (>=1).
- DATA_W, 32, result width (word_t).
- REG_AW, 5, architectural register address width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset, sampled on rising CLK.
- src_valid  in  NUM_SRC  channel i carries a result this cycle.
- src_rd  in  NUM_SRC*REG_AW  destination register, channel i at [i*REG_AW +: REG_AW].
- src_data  in  NUM_SRC*DATA_W  result data, packed the same way.
- flush  in  1  pipeline squash; invalidates all held results.
- rd_addr  in  NUM_RD*REG_AW  source register requested per read port.
- rd_ena  out  NUM_RD  bypass hit per port.
- rd_data  out  NUM_RD*DATA_W  forwarded data per port; 0 when no hit.
- rd_age  out  NUM_RD*$clog2(HOLD_DEPTH+2)  hit source: 0=live, k=history stage k-1; 0 on miss.

Behaviour:
- Lookup is combinational, 0-cycle latency, from rd_addr to rd_ena/rd_data/rd_age.
- Candidate priority, newest first:
  - live channels;
  - then history stage 0 (captured last cycle), stage 1, ..., stage HOLD_DEPTH-1.
  - Within a stage, the lowest channel index wins.
- rd_addr==0 never hits: rd_ena=0, rd_data=0, rd_age=0.
- Channels with src_rd==0 are neither forwarded nor captured.
- History buffer is a shift register; each stage holds NUM_SRC slots {valid, rd, data}. On each rising CLK with nRST=1 and flush=0:
  - stage0 <= live channels, with valid = src_valid & (src_rd!=0);
  - stage k <= stage k-1;
  - the last stage's contents are discarded (aged out).
- An entry is visible for exactly HOLD_DEPTH cycles after its writeback cycle, then disappears with no further action.
- A newer write to the same rd shadows older entries through priority alone. Older entries are not invalidated.
- flush=1:
  - rd_ena forced to all 0 in that cycle (live channels are not forwarded);
  - at the edge, every history valid is cleared and the current live channels are not captured;
  - the cycle after flush, only new live results can hit.
- nRST=0 at an edge clears all history valids (rd/data are don't-care).
- While nRST=0, rd_ena=0, rd_data=0 and rd_age=0, regardless of inputs.
- Reset or flush asserted mid-stream takes priority over capture in the same edge.
- flush and nRST=0 in the same cycle behave as reset.
- Multiple read ports may hit the same entry simultaneously. Ports are independent.
- No backpressure. The buffer advances every cycle; a stalled consumer is responsible for reading within HOLD_DEPTH cycles.

Optional Feature:
- Macro OOO_BYPASS_PERF_CNT_EN.
- When defined:
  - adds outputs perf_live_hits and perf_hold_hits, 32-bit each;
  - per cycle, each counter increments by the number of ports with rd_ena=1 whose rd_age==0 (live) or !=0 (hold);
  - counters wrap modulo 2^32;
  - cleared by nRST=0; not cleared by flush.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Live priority:
  - Stimulus: ch0 {valid, rd=5, 0xAAAA0000} and ch3 {valid, rd=5, 0x33333333}; rd_addr port0=5.
  - Required: same cycle rd_ena[0]=1, rd_data=0xAAAA0000, rd_age=0.
- Hold aging (HOLD_DEPTH=2):
  - Stimulus: ch1 writes rd=7, 0x12345678 at cycle N; then idle; port1 reads 7.
  - Required: hit with age 1 at N+1, hit with age 2 at N+2, miss (rd_ena=0, rd_data=0) at N+3.
- Shadowing:
  - Stimulus: ch2 writes rd=9, 0x1 at N; ch0 writes rd=9, 0x2 at N+1; read 9.
  - Required: N+1 returns 0x2 age 0; N+2 returns 0x2 age 1.
- x0:
  - Stimulus: ch0 {valid, rd=0, 0xFFFFFFFF}; rd_addr=0 in the same cycle and the next.
  - Required: rd_ena=0 and rd_data=0 in both cycles.
- Flush:
  - Stimulus: rd=4 captured at N; flush=1 at N+1 with ch0 writing rd=4, 0x55.
  - Required: rd_ena=0 at N+1; miss on rd=4 at N+2.
- Reset mid-stream:
  - Stimulus: history holds rd=3; nRST=0 for one edge with live ch0 rd=3.
  - Required: outputs 0 during reset; miss on rd=3 after release.
  - Perf build only: counters read 0 after release.

Source files
------------

// File: rtl/ooo_bypass_network.sv
// ooo_bypass_network: forwards writeback results from NUM_SRC channels to
// NUM_RD operand read ports, with a HOLD_DEPTH-stage history buffer so that
// late consumers still see a result before the register file is updated.
// Optional performance counters are enabled by defining OOO_BYPASS_PERF_CNT_EN.
module ooo_bypass_network #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_RD     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  localparam int AGE_W     = $clog2(HOLD_DEPTH + 2)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  src_rd,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic                       flush,
  input  logic [NUM_RD*REG_AW-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          rd_ena,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD*AGE_W-1:0]    rd_age
`ifdef OOO_BYPASS_PERF_CNT_EN
  ,
  output logic [31:0]                perf_live_hits,
  output logic [31:0]                perf_hold_hits
`endif
);

  // History stage 0 is the newest (captured last cycle); the highest index
  // is the oldest and is dropped on the next edge.
  logic [NUM_SRC-1:0]                         live_valid;
  logic [HOLD_DEPTH-1:0][NUM_SRC-1:0]         hist_valid_q, hist_valid_d;
  logic [HOLD_DEPTH-1:0][NUM_SRC*REG_AW-1:0]  hist_rd_q, hist_rd_d;
  logic [HOLD_DEPTH-1:0][NUM_SRC*DATA_W-1:0]  hist_data_q, hist_data_d;

  // Qualify live channels: writes to x0 are neither forwarded nor captured.
  always_comb begin
    live_valid = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      live_valid[s] = src_valid[s] && (src_rd[s*REG_AW +: REG_AW] != '0);
    end
  end

  // Shift the history buffer one stage; a flush drops every valid and
  // keeps the current live channels from being captured.
  always_comb begin
    hist_valid_d   = '0;
    hist_rd_d      = hist_rd_q;
    hist_data_d    = hist_data_q;
    hist_valid_d[0] = flush ? '0 : live_valid;
    hist_rd_d[0]    = src_rd;
    hist_data_d[0]  = src_data;
    for (int k = 1; k < HOLD_DEPTH; k++) begin
      hist_valid_d[k] = flush ? '0 : hist_valid_q[k-1];
      hist_rd_d[k]    = hist_rd_q[k-1];
      hist_data_d[k]  = hist_data_q[k-1];
    end
  end

  // History registers; only the valid bits need reset, rd/data are don't-care
  // whenever their valid is clear.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hist_valid_q <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
    end
    hist_rd_q   <= hist_rd_d;
    hist_data_q <= hist_data_d;
  end

  // Per-port lookup, newest candidate first: live channels, then history
  // stages in age order; within a stage the lowest channel index wins.
  // The port's own rd_ena bit doubles as the "already found" flag.
  always_comb begin
    rd_ena  = '0;
    rd_data = '0;
    rd_age  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (nRST && !flush && (rd_addr[p*REG_AW +: REG_AW] != '0)) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (!rd_ena[p] && live_valid[s] &&
              (src_rd[s*REG_AW +: REG_AW] == rd_addr[p*REG_AW +: REG_AW])) begin
            rd_ena[p]                   = 1'b1;
            rd_data[p*DATA_W +: DATA_W] = src_data[s*DATA_W +: DATA_W];
            rd_age[p*AGE_W +: AGE_W]    = '0;
          end
        end
        for (int k = 0; k < HOLD_DEPTH; k++) begin
          for (int s = 0; s < NUM_SRC; s++) begin
            if (!rd_ena[p] && hist_valid_q[k][s] &&
                (hist_rd_q[k][s*REG_AW +: REG_AW] == rd_addr[p*REG_AW +: REG_AW])) begin
              rd_ena[p]                   = 1'b1;
              rd_data[p*DATA_W +: DATA_W] = hist_data_q[k][s*DATA_W +: DATA_W];
              rd_age[p*AGE_W +: AGE_W]    = AGE_W'(k + 1);
            end
          end
        end
      end
    end
  end

`ifdef OOO_BYPASS_PERF_CNT_EN
  logic [31:0] perf_live_hits_q, perf_live_hits_d;
  logic [31:0] perf_hold_hits_q, perf_hold_hits_d;

  // Accumulate per-cycle hit counts split by live versus held source.
  always_comb begin
    perf_live_hits_d = perf_live_hits_q;
    perf_hold_hits_d = perf_hold_hits_q;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_ena[p]) begin
        if (rd_age[p*AGE_W +: AGE_W] == '0) begin
          perf_live_hits_d = perf_live_hits_d + 32'd1;
        end else begin
          perf_hold_hits_d = perf_hold_hits_d + 32'd1;
        end
      end
    end
  end

  // Counter registers; flush deliberately leaves them untouched.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_live_hits_q <= '0;
      perf_hold_hits_q <= '0;
    end else begin
      perf_live_hits_q <= perf_live_hits_d;
      perf_hold_hits_q <= perf_hold_hits_d;
    end
  end

  assign perf_live_hits = perf_live_hits_q;
  assign perf_hold_hits = perf_hold_hits_q;
`endif

endmodule

// File: tb/tb_ooo_bypass_network.sv
// Scoreboard bench for ooo_bypass_network: stimulus pushes expected port
// responses into a queue, a monitor on the falling edge pops and compares.
module tb_ooo_bypass_network;

  localparam int NUM_SRC    = 4;
  localparam int NUM_RD     = 2;
  localparam int HOLD_DEPTH = 2;
  localparam int DATA_W     = 32;
  localparam int REG_AW     = 5;
  localparam int AGE_W      = $clog2(HOLD_DEPTH + 2);

  logic                      CLK;
  logic                      nRST;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*REG_AW-1:0] src_rd;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      flush;
  logic [NUM_RD*REG_AW-1:0]  rd_addr;
  logic [NUM_RD-1:0]         rd_ena;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD*AGE_W-1:0]   rd_age;
`ifdef OOO_BYPASS_PERF_CNT_EN
  logic [31:0]               perf_live_hits;
  logic [31:0]               perf_hold_hits;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int          port;
    logic        ena;
    logic [31:0] data;
    logic [1:0]  age;
    string       name;
  } exp_t;

  exp_t expQ[$];

  ooo_bypass_network #(
    .NUM_SRC(NUM_SRC), .NUM_RD(NUM_RD), .HOLD_DEPTH(HOLD_DEPTH),
    .DATA_W(DATA_W), .REG_AW(REG_AW)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .src_valid(src_valid),
    .src_rd(src_rd),
    .src_data(src_data),
    .flush(flush),
    .rd_addr(rd_addr),
    .rd_ena(rd_ena),
    .rd_data(rd_data),
    .rd_age(rd_age)
`ifdef OOO_BYPASS_PERF_CNT_EN
    ,
    .perf_live_hits(perf_live_hits),
    .perf_hold_hits(perf_hold_hits)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic [NUM_SRC-1:0] v,
                               input logic [NUM_SRC*REG_AW-1:0] r,
                               input logic [NUM_SRC*DATA_W-1:0] d,
                               input logic fl,
                               input logic rn,
                               input logic [NUM_RD*REG_AW-1:0] a);
    @(posedge CLK);
    #1;
    src_valid = v;
    src_rd    = r;
    src_data  = d;
    flush     = fl;
    nRST      = rn;
    rd_addr   = a;
  endtask

  // Queue an expected response for the current cycle.
  task automatic expectPort(input int p, input logic e, input logic [31:0] d,
                            input logic [1:0] ag, input string nm);
    exp_t x;
    x.port = p;
    x.ena  = e;
    x.data = d;
    x.age  = ag;
    x.name = nm;
    expQ.push_back(x);
  endtask

  task automatic expectMiss(input int p, input string nm);
    expectPort(p, 1'b0, 32'h0, 2'd0, nm);
  endtask

  // Compare one scoreboard entry against the DUT's current outputs.
  task automatic checkOutput(input exp_t x);
    logic        aEna;
    logic [31:0] aData;
    logic [1:0]  aAge;
    aEna  = rd_ena[x.port];
    aData = rd_data[x.port*DATA_W +: DATA_W];
    aAge  = rd_age[x.port*AGE_W +: AGE_W];
    testsRun++;
    if (aEna !== x.ena || aData !== x.data || aAge !== x.age) begin
      testsFailed++;
      $display("[TB] FAIL %s port%0d: got ena=%0b data=%h age=%0d, want ena=%0b data=%h age=%0d",
               x.name, x.port, aEna, aData, aAge, x.ena, x.data, x.age);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      while (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    flush     = 1'b0;
    nRST      = 1'b0;
    rd_addr   = '0;

    // Reset: outputs held at zero even with a matching live channel.
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {96'h0, 32'hDEADBEEF}, 1'b0, 1'b0, {5'd5, 5'd5});
    expectMiss(0, "reset_p0");
    expectMiss(1, "reset_p1");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b0, {5'd5, 5'd5});
    expectMiss(0, "reset_hist_p0");

    // Live priority: ch0 beats ch3 on rd=5; both ports hit the same entry.
    applyStimulus(4'b1001, {5'd5, 5'd0, 5'd0, 5'd5},
                  {32'h33333333, 32'h0, 32'h0, 32'hAAAA0000}, 1'b0, 1'b1, {5'd5, 5'd5});
    expectPort(0, 1'b1, 32'hAAAA0000, 2'd0, "live_prio_p0");
    expectPort(1, 1'b1, 32'hAAAA0000, 2'd0, "live_prio_p1");

    // Hold aging on rd=7 via port1; port0 follows rd=5 through the history.
    applyStimulus(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0},
                  {32'h0, 32'h0, 32'h12345678, 32'h0}, 1'b0, 1'b1, {5'd7, 5'd5});
    expectPort(1, 1'b1, 32'h12345678, 2'd0, "age_live");
    expectPort(0, 1'b1, 32'hAAAA0000, 2'd1, "stage_prio_age1");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd7, 5'd5});
    expectPort(1, 1'b1, 32'h12345678, 2'd1, "age1");
    expectPort(0, 1'b1, 32'hAAAA0000, 2'd2, "stage_prio_age2");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd7, 5'd5});
    expectPort(1, 1'b1, 32'h12345678, 2'd2, "age2");
    expectMiss(0, "aged_out_rd5");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd7, 5'd0});
    expectMiss(1, "aged_out_rd7");

    // Shadowing on rd=9: the newer write wins at every age.
    applyStimulus(4'b0100, {5'd0, 5'd9, 5'd0, 5'd0},
                  {32'h0, 32'h1, 32'h0, 32'h0}, 1'b0, 1'b1, {5'd0, 5'd9});
    expectPort(0, 1'b1, 32'h1, 2'd0, "shadow_first");
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd9},
                  {96'h0, 32'h2}, 1'b0, 1'b1, {5'd0, 5'd9});
    expectPort(0, 1'b1, 32'h2, 2'd0, "shadow_live");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd0, 5'd9});
    expectPort(0, 1'b1, 32'h2, 2'd1, "shadow_age1");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd0, 5'd9});
    expectPort(0, 1'b1, 32'h2, 2'd2, "shadow_age2");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd0, 5'd9});
    expectMiss(0, "shadow_gone");

    // x0 never hits, live or held.
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd0},
                  {96'h0, 32'hFFFFFFFF}, 1'b0, 1'b1, {5'd0, 5'd0});
    expectMiss(0, "x0_live_p0");
    expectMiss(1, "x0_live_p1");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd0, 5'd0});
    expectMiss(0, "x0_next");

    // Flush: rd=4 captured, then squashed along with the live write.
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd4},
                  {96'h0, 32'h44}, 1'b0, 1'b1, {5'd0, 5'd4});
    expectPort(0, 1'b1, 32'h44, 2'd0, "pre_flush");
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd4},
                  {96'h0, 32'h55}, 1'b1, 1'b1, {5'd4, 5'd4});
    expectMiss(0, "flush_cycle_p0");
    expectMiss(1, "flush_cycle_p1");
    applyStimulus(4'b0010, {5'd0, 5'd0, 5'd8, 5'd0},
                  {32'h0, 32'h0, 32'h66, 32'h0}, 1'b0, 1'b1, {5'd8, 5'd4});
    expectMiss(0, "post_flush_rd4");
    expectPort(1, 1'b1, 32'h66, 2'd0, "post_flush_live");

    // Reset mid-stream with rd=3 in history and a live rd=3 write.
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},
                  {96'h0, 32'h33}, 1'b0, 1'b1, {5'd3, 5'd3});
    expectPort(0, 1'b1, 32'h33, 2'd0, "pre_reset");
    applyStimulus(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},
                  {96'h0, 32'h77}, 1'b0, 1'b0, {5'd3, 5'd3});
    expectMiss(0, "mid_reset_p0");
    expectMiss(1, "mid_reset_p1");
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b1, {5'd3, 5'd3});
    expectMiss(0, "after_reset_p0");
    expectMiss(1, "after_reset_p1");
`ifdef OOO_BYPASS_PERF_CNT_EN
    @(negedge CLK);
    #1;
    testsRun++;
    if (perf_live_hits !== 32'd0 || perf_hold_hits !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL perf_after_reset: got live=%0d hold=%0d, want 0 and 0",
               perf_live_hits, perf_hold_hits);
    end
`endif

    // Let the monitor drain, then confirm nothing was left unchecked.
    @(negedge CLK);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
